disp_scan: RTL and testbench

Sequential front end for the `decode7` seven-segment decoder. It accepts a binary value, converts it to four BCD digits with a one-bit-per-cycle double-dabble engine, and time-multiplexes the digits onto a shared 4-bit `num` bus with an active-low one-hot digit enable. It sits between the radar range/angle logic and the per-segment decoder, and its `num` codes follow the decoder's code space: 0–9 are digits, A–E are digits 0–4 with a decimal point, and F is blank.

---
 rtl/disp_scan.sv | 152 +++++++++++++++
 tb/tb_disp_scan.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan.sv
`default_nettype none
// ============================================================================
// Module   : disp_scan
// Purpose  : Binary-to-BCD (double dabble) front end that scans four digits
//            onto a shared num bus for decode7. Optional macro DISP_DP_EN
//            adds a decimal point on digit DP_POS.
// Revision : 1.0 - initial release
// ============================================================================
module disp_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int DP_POS   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [13:0] value,
    input  logic        load,
    output logic        busy,
    output logic [3:0]  num,
    output logic [3:0]  digit
);

`ifdef DISP_DP_EN
    localparam bit c_DP_EN = 1'b1;
`else
    localparam bit c_DP_EN = 1'b0;
`endif

    // Digits at or below this index are never blanked.
    localparam int c_FLOOR = c_DP_EN ? DP_POS : 0;

    localparam int                 c_PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(SCAN_DIV - 1);
    localparam logic [13:0]        c_SAT     = 14'd9999;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic [13:0]         r_bin;
    logic [15:0]         r_bcd;
    logic [3:0]          r_cnt;
    logic [15:0]         r_disp;
    logic [c_PRE_W-1:0]  r_pre;
    logic [1:0]          r_idx;
    logic [3:0]          r_num;
    logic [3:0]          r_digit;

    logic [13:0]         w_sat;
    logic [15:0]         w_adj;
    logic                w_wrap;
    logic [1:0]          w_idx_nxt;
    logic [15:0]         w_disp_nxt;

    function automatic logic [3:0] f_code(input logic [15:0] d, input logic [1:0] i);
        logic [3:0] dig;
        logic       blank;
        dig   = d[4*i +: 4];
        blank = (int'(i) > c_FLOOR);
        for (int k = 0; k < 4; k++) begin
            if (k >= int'(i) && d[4*k +: 4] != 4'd0) begin
                blank = 1'b0;
            end
        end
        if (blank) begin
            f_code = 4'hF;
        end else if (c_DP_EN && int'(i) == DP_POS && dig <= 4'd4) begin
            f_code = dig + 4'd10;
        end else begin
            f_code = dig;
        end
    endfunction

    assign w_sat = (value > c_SAT) ? c_SAT : value;

    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < 4; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_bin   <= 14'd0;
            r_bcd   <= 16'd0;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_bin   <= w_sat;
                        r_bcd   <= 16'd0;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
                    r_cnt          <= r_cnt + 4'd1;
                    if (r_cnt == 4'd13) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // num/digit are built from next-state values so a commit landing on a
    // digit advance shows the new value on the very edge the digit switches.
    assign w_wrap     = (r_pre == c_PRE_MAX);
    assign w_idx_nxt  = w_wrap ? (r_idx + 2'd1) : r_idx;
    assign w_disp_nxt = (r_state == S_COMMIT) ? r_bcd : r_disp;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pre   <= '0;
            r_idx   <= 2'd0;
            r_disp  <= 16'd0;
            r_num   <= 4'h0;
            r_digit <= 4'b1110;
        end else begin
            r_pre   <= w_wrap ? '0 : (r_pre + 1'b1);
            r_idx   <= w_idx_nxt;
            r_disp  <= w_disp_nxt;
            r_num   <= f_code(w_disp_nxt, w_idx_nxt);
            r_digit <= ~(4'b0001 << w_idx_nxt);
        end
    end

    assign busy  = r_busy;
    assign num   = r_num;
    assign digit = r_digit;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_scan
// Purpose  : Scoreboard bench for disp_scan; expected scan frames are queued
//            by the stimulus and checked by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_scan;

    localparam int SD = 4;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        load    = 1'b0;
    logic [13:0] value   = 14'd0;
    logic        busy;
    logic [3:0]  num;
    logic [3:0]  digit;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    disp_scan #(.SCAN_DIV(SD), .DP_POS(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .value   (value),
        .load    (load),
        .busy    (busy),
        .num     (num),
        .digit   (digit)
    );

    // Monitor: every digit change is a presented output; pop and compare.
    initial begin : g_mon
        logic [3:0] prev;
        logic [7:0] e;
        int         hold;
        bit         have;
        prev = 4'b1110;
        hold = 0;
        have = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                have = 1'b0;
                hold = 0;
                prev = digit;
            end else if (digit !== prev) begin
                if (have) begin
                    n_cmp++;
                    if (hold != SD) begin
                        n_err++;
                        $display("FAIL hold digit=%b got %0d cycles want %0d", prev, hold, SD);
                    end
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_cmp++;
                    if ({digit, num} !== e) begin
                        n_err++;
                        $display("FAIL scan digit/num got %b/%h want %b/%h",
                                 digit, num, e[7:4], e[3:0]);
                    end
                end
                have = 1'b1;
                hold = 1;
                prev = digit;
            end else begin
                hold++;
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic do_load(input logic [13:0] v);
        int cnt;
        load  = 1'b1;
        value = v;
        @(negedge clk);
        load = 1'b0;
        cnt  = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (cnt != 15) begin
            n_err++;
            $display("FAIL busy_len value=%0d got %0d want 15", v, cnt);
        end
    endtask

    task automatic wait_drain(input string nm);
        int t;
        t = 0;
        while (sb.size() > 0 && t < 80) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout got %0d pending want 0", nm, sb.size());
            sb.delete();
        end
    endtask

    // Expected digits packed {d3,d2,d1,d0}; queued for the next full frame.
    task automatic check_frame(input string nm, input logic [15:0] exp);
        int t;
        logic [3:0] one;
        one = 4'b0001;
        t   = 0;
        while (digit !== 4'b0111 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s sync got digit %b want 0111", nm, digit);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            sb.push_back({~(one << k), exp[4*k +: 4]});
        end
        wait_drain(nm);
    endtask

    // Load timed so the commit edge coincides with a digit advance.
    task automatic commit_test(input logic [13:0] v, input logic [15:0] olds,
                               input logic [15:0] news);
        logic [3:0] prev;
        logic [3:0] one;
        int t;
        int j;
        one  = 4'b0001;
        prev = digit;
        t    = 0;
        while (digit === prev && t < 40) begin
            @(negedge clk);
            t++;
        end
        j = 0;
        for (int k = 0; k < 4; k++) begin
            if (digit == ~(one << k)) j = k;
        end
        load  = 1'b1;
        value = v;
        @(posedge clk);
        #1;
        load = 1'b0;
        for (int n = 1; n < 4; n++) begin
            sb.push_back({~(one << ((j + n) % 4)), olds[4*((j + n) % 4) +: 4]});
        end
        sb.push_back({~(one << j), news[4*j +: 4]});
        wait_drain("commit_align");
        @(negedge clk);
    endtask

    initial begin : g_watchdog
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : g_stim
        int t;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_num",   {4'h0, num},   8'h00);
        chk("reset_digit", {4'h0, digit}, 8'h0E);
        chk("reset_busy",  {7'h0, busy},  8'h00);
        reset_n = 1'b1;
        @(negedge clk);

        do_load(14'd1234);
`ifdef DISP_DP_EN
        check_frame("v1234", 16'h1C34);
`else
        check_frame("v1234", 16'h1234);
`endif
        do_load(14'd16383);
        check_frame("v16383", 16'h9999);
        do_load(14'd7);
`ifdef DISP_DP_EN
        check_frame("v7", 16'hFA07);
`else
        check_frame("v7", 16'hFFF7);
`endif
        do_load(14'd0);
`ifdef DISP_DP_EN
        check_frame("v0", 16'hFA00);
`else
        check_frame("v0", 16'hFFF0);
`endif

        // Second load three cycles into a conversion must be dropped.
        load  = 1'b1;
        value = 14'd1234;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        load  = 1'b1;
        value = 14'd5678;
        @(negedge clk);
        load = 1'b0;
        t = 0;
        while (busy === 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
`ifdef DISP_DP_EN
        check_frame("busy_drop", 16'h1C34);
`else
        check_frame("busy_drop", 16'h1234);
`endif
        do_load(14'd5678);
        check_frame("v5678", 16'h5678);

`ifdef DISP_DP_EN
        commit_test(14'd4321, 16'h5678, 16'h4D21);
        check_frame("v4321", 16'h4D21);
`else
        commit_test(14'd4321, 16'h5678, 16'h4321);
        check_frame("v4321", 16'h4321);
`endif

        // Reset on the 7th cycle of a conversion.
        load  = 1'b1;
        value = 14'd9999;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_num",   {4'h0, num},   8'h00);
        chk("midrst_digit", {4'h0, digit}, 8'h0E);
        chk("midrst_busy",  {7'h0, busy},  8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_idle", {7'h0, busy}, 8'h00);
`ifdef DISP_DP_EN
        check_frame("midrst_frame", 16'hFA00);
        do_load(14'd5);
        check_frame("dp5", 16'hFA05);
        do_load(14'd750);
        check_frame("dp750", 16'hF750);
`else
        check_frame("midrst_frame", 16'hFFF0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
